// File: rtl/branch_issue_scheduler.sv
// Round-robin issue of reservation-station branches to the single branch-check unit.
// One branch in flight; outcome is broadcast to the ROB as a flush or resolve-OK pulse.
module branch_issue_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32,
    parameter int CHECK_LAT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rs1_data,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rs2_data,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic                        bc_valid,
    output logic [DATA_W-1:0]           bc_rs1_data,
    output logic [DATA_W-1:0]           bc_rs2_data,
    output logic [TAG_W-1:0]            bc_tag,
    input  logic                        bc_result_valid,
    input  logic [TAG_W-1:0]            bc_result_tag,
    input  logic                        flush_in,
    output logic                        flush_out,
    output logic [TAG_W-1:0]            flush_tag,
    output logic                        resolve_ok,
    output logic [TAG_W-1:0]            resolve_tag,
    output logic                        busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    state_t                           state, state_nxt;
    logic [IDX_W-1:0]                 ptr;
    logic [CNT_W-1:0]                 cnt;
    logic [NUM_REQ-1:0][TAG_W-1:0]    tag_a;
    logic [NUM_REQ-1:0][DATA_W-1:0]   rs1_a, rs2_a;
    logic                             sel_found;
    logic [IDX_W-1:0]                 sel_idx;
    logic                             take, hit, win_end;
    logic [NUM_REQ-1:0]               grant_d;
    logic                             flush_d, resolve_d, busy_d;

    assign tag_a = req_tag;
    assign rs1_a = req_rs1_data;
    assign rs2_a = req_rs2_data;

    // First valid entry strictly after the last winner, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(idx);
            end
        end
    end

    assign take    = (state == IDLE) && sel_found && !flush_in;
    assign hit     = bc_result_valid && (bc_result_tag == bc_tag) &&
                     ((state == ISSUE) || (state == WAIT));
    assign win_end = (state == WAIT) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        if (flush_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sel_found) state_nxt = ISSUE;
                ISSUE:   state_nxt = hit ? REPORT : WAIT;
                WAIT:    if (hit || win_end) state_nxt = REPORT;
                REPORT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; a mispredict match beats window expiry.
    always_comb begin
        grant_d = '0;
        if (take) grant_d[sel_idx] = 1'b1;
        flush_d   = !flush_in && hit;
        resolve_d = !flush_in && win_end && !hit;
        busy_d    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
            req_grant   <= '0;
            bc_valid    <= 1'b0;
            bc_rs1_data <= '0;
            bc_rs2_data <= '0;
            bc_tag      <= '0;
            flush_out   <= 1'b0;
            flush_tag   <= '0;
            resolve_ok  <= 1'b0;
            resolve_tag <= '0;
            busy        <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_grant  <= grant_d;
            bc_valid   <= take;
            flush_out  <= flush_d;
            resolve_ok <= resolve_d;
            busy       <= busy_d;
            if (take) begin
                ptr         <= sel_idx;
                bc_tag      <= tag_a[sel_idx];
                bc_rs1_data <= rs1_a[sel_idx];
                bc_rs2_data <= rs2_a[sel_idx];
            end
            if (state == ISSUE)
                cnt <= CNT_W'(CHECK_LAT - 1);
            else if ((state == WAIT) && (cnt != '0))
                cnt <= cnt - CNT_W'(1);
            if (flush_d)   flush_tag   <= bc_tag;
            if (resolve_d) resolve_tag <= bc_tag;
        end
    end
endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Bench for branch_issue_scheduler: vector table driving a grant/outcome scoreboard,
// plus hand sequences for flush, reset-abort and round-robin fairness.
module tb_branch_issue_scheduler;
    localparam int NUM_REQ = 4, TAG_W = 3, DATA_W = 32, CHECK_LAT = 4;

    logic                       clk = 1'b0, rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*TAG_W-1:0]   req_tag;
    logic [NUM_REQ*DATA_W-1:0]  req_rs1_data, req_rs2_data;
    logic [NUM_REQ-1:0]         req_grant;
    logic                       bc_valid, bc_result_valid, flush_in;
    logic [DATA_W-1:0]          bc_rs1_data, bc_rs2_data;
    logic [TAG_W-1:0]           bc_tag, bc_result_tag, flush_tag, resolve_tag;
    logic                       flush_out, resolve_ok, busy;

    branch_issue_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W),
                             .CHECK_LAT(CHECK_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
        .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data), .req_grant(req_grant),
        .bc_valid(bc_valid), .bc_rs1_data(bc_rs1_data), .bc_rs2_data(bc_rs2_data),
        .bc_tag(bc_tag), .bc_result_valid(bc_result_valid), .bc_result_tag(bc_result_tag),
        .flush_in(flush_in), .flush_out(flush_out), .flush_tag(flush_tag),
        .resolve_ok(resolve_ok), .resolve_tag(resolve_tag), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         base;
        int         dly;    // cycles after bc_valid to report; -1 = no report
        logic [2:0] rtag;
        int         win;
        logic       flush;
        int         lat;    // bc_valid cycle to outcome cycle
    } vec_t;
    typedef struct { logic [3:0] grant; logic [2:0] tag; logic [31:0] rs1, rs2; } gexp_t;
    typedef struct { logic flush; logic [2:0] tag; int lat; } oexp_t;

    gexp_t gq[$];
    oexp_t oq[$];
    vec_t  vt[7];
    int    total = 0, bad = 0, cyc = 0, issue_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic logic [2:0] tagf(int base, int i);
        return 3'((base + i) % 8);
    endfunction
    function automatic logic [31:0] rs1f(int base, int i);
        return 32'(base * 256 + i * 16 + 1);
    endfunction

    task automatic set_data(input int base);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tag[i*TAG_W +: TAG_W]       = tagf(base, i);
            req_rs1_data[i*DATA_W +: DATA_W] = rs1f(base, i);
            req_rs2_data[i*DATA_W +: DATA_W] = ~rs1f(base, i);
        end
    endtask

    task automatic push_exp(input int base, input int win, input bit with_out,
                            input logic fl, input int lat);
        gexp_t g;
        oexp_t o;
        g.grant = 4'b0001 << win;
        g.tag   = tagf(base, win);
        g.rs1   = rs1f(base, win);
        g.rs2   = ~rs1f(base, win);
        gq.push_back(g);
        if (with_out) begin
            o.flush = fl;
            o.tag   = tagf(base, win);
            o.lat   = lat;
            oq.push_back(o);
        end
    endtask

    // Scoreboard: compare grants and outcomes mid-cycle against queued expectations.
    always @(negedge clk) if (rst_n) begin
        if (bc_valid) issue_cyc = cyc;
        if (req_grant != '0) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_grant got=%b", req_grant);
            end else begin
                gexp_t g;
                g = gq.pop_front();
                if (req_grant !== g.grant || bc_valid !== 1'b1 || bc_tag !== g.tag ||
                    bc_rs1_data !== g.rs1 || bc_rs2_data !== g.rs2) begin
                    bad++;
                    $display("FAIL grant got g=%b v=%b tag=%0d rs1=%h rs2=%h exp g=%b tag=%0d rs1=%h rs2=%h",
                             req_grant, bc_valid, bc_tag, bc_rs1_data, bc_rs2_data,
                             g.grant, g.tag, g.rs1, g.rs2);
                end
            end
        end else if (bc_valid) begin
            total++; bad++;
            $display("FAIL bc_valid_without_grant got=1 exp=0");
        end
        if (flush_out || resolve_ok) begin
            total++;
            if (oq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_outcome flush=%b resolve=%b", flush_out, resolve_ok);
            end else begin
                oexp_t o;
                logic [2:0] t;
                o = oq.pop_front();
                t = o.flush ? flush_tag : resolve_tag;
                if (flush_out !== o.flush || resolve_ok !== !o.flush || t !== o.tag ||
                    (cyc - issue_cyc) != o.lat) begin
                    bad++;
                    $display("FAIL outcome got fl=%b ok=%b tag=%0d lat=%0d exp fl=%b tag=%0d lat=%0d",
                             flush_out, resolve_ok, t, cyc - issue_cyc, o.flush, o.tag, o.lat);
                end
            end
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk); #1;
            if (req_grant != '0) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL grant_timeout got=none exp=grant within 20 cycles");
        end
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 30 && busy; k++) begin
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout busy=%b exp=0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (gq.size() != 0 || oq.size() != 0) begin
            bad++;
            $display("FAIL %s pending grants=%0d outcomes=%0d exp=0", name, gq.size(), oq.size());
            gq.delete();
            oq.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        set_data(v.base);
        push_exp(v.base, v.win, 1'b1, v.flush, v.lat);
        req_valid = v.req;
        wait_grant(ok);
        req_valid = '0;
        if (ok && v.dly >= 0) begin
            repeat (v.dly) begin @(posedge clk); #1; end
            bc_result_valid = 1'b1;
            bc_result_tag   = v.rtag;
            @(posedge clk); #1;
            bc_result_valid = 1'b0;
        end
        wait_idle();
        check_drained("vector_outcome");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int prev;
        rst_n = 1'b0; req_valid = '0; req_tag = '0; req_rs1_data = '0; req_rs2_data = '0;
        bc_result_valid = 1'b0; bc_result_tag = '0; flush_in = 1'b0;
        #3;
        total++;
        if ({req_grant, bc_valid, flush_out, resolve_ok, busy} !== '0 || bc_tag !== '0 ||
            bc_rs1_data !== '0 || flush_tag !== '0 || resolve_tag !== '0) begin
            bad++;
            $display("FAIL reset_state g=%b v=%b fl=%b ok=%b busy=%b tag=%0d exp all 0",
                     req_grant, bc_valid, flush_out, resolve_ok, busy, bc_tag);
        end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        //          req      base dly rtag  win flush lat
        vt[0] = '{4'b0001, 5,  2, 3'd5, 0, 1'b1, 3};  // mispredict two cycles after issue
        vt[1] = '{4'b0010, 2, -1, 3'd0, 1, 1'b0, 5};  // no report -> resolve
        vt[2] = '{4'b0101, 4,  1, 3'd2, 2, 1'b0, 5};  // wrong tag ignored
        vt[3] = '{4'b0101, 7,  0, 3'd7, 0, 1'b1, 1};  // report during issue cycle
        vt[4] = '{4'b1000, 0,  4, 3'd3, 3, 1'b1, 5};  // report on last window cycle
        vt[5] = '{4'b1000, 1,  5, 3'd4, 3, 1'b0, 5};  // report after window ignored
        vt[6] = '{4'b0110, 3, -1, 3'd0, 1, 1'b0, 5};
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // flush_in in IDLE suppresses a grant
        set_data(0);
        req_valid = 4'b0001; flush_in = 1'b1;
        @(posedge clk); #1;
        req_valid = '0; flush_in = 1'b0;
        total++;
        if (req_grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_grant got g=%b busy=%b exp 0", req_grant, busy);
        end
        @(posedge clk); #1;

        // flush_in collides with a matching report: nothing broadcast
        push_exp(0, 2, 1'b0, 1'b0, 0);
        req_valid = 4'b0100;
        wait_grant(ok);
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        bc_result_valid = 1'b1; bc_result_tag = tagf(0, 2); flush_in = 1'b1;
        @(posedge clk); #1;
        bc_result_valid = 1'b0; flush_in = 1'b0;
        total++;
        if (busy !== 1'b0 || flush_out !== 1'b0 || resolve_ok !== 1'b0 || req_grant !== '0) begin
            bad++;
            $display("FAIL flush_collision busy=%b fl=%b ok=%b g=%b exp 0",
                     busy, flush_out, resolve_ok, req_grant);
        end
        repeat (8) @(posedge clk); #1;
        check_drained("flush_collision_drain");
        run_vec('{4'b1101, 2, -1, 3'd0, 3, 1'b0, 5});  // pointer kept at 2

        // async reset in WAIT aborts the branch
        set_data(6);
        push_exp(6, 1, 1'b0, 1'b0, 0);
        req_valid = 4'b0010;
        wait_grant(ok);
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_grant, bc_valid, flush_out, resolve_ok, busy} !== '0 || bc_tag !== '0 ||
            bc_rs1_data !== '0 || bc_rs2_data !== '0) begin
            bad++;
            $display("FAIL reset_mid_wait g=%b v=%b fl=%b ok=%b busy=%b tag=%0d exp all 0",
                     req_grant, bc_valid, flush_out, resolve_ok, busy, bc_tag);
        end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        check_drained("reset_drain");

        // round-robin with all entries held valid from reset
        set_data(1);
        for (int n = 0; n < 5; n++) push_exp(1, n % NUM_REQ, 1'b1, 1'b0, CHECK_LAT + 1);
        req_valid = 4'b1111;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant(ok);
            if (n > 0) begin
                total++;
                if (cyc - prev != CHECK_LAT + 3) begin
                    bad++;
                    $display("FAIL rr_spacing got=%0d exp=%0d", cyc - prev, CHECK_LAT + 3);
                end
            end
            prev = cyc;
        end
        req_valid = '0;
        wait_idle();
        check_drained("rr_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_issue_scheduler.md
Name: branch_issue_scheduler

Overview:
- Shares the single branch-check unit among NUM_REQ branch reservation-station entries.
- Arbitrates round-robin and latches the winner's operands and ROB tag.
- Drives a one-cycle issue pulse to the branch-check unit, then waits a bounded window for its misprediction report.
- Converts the outcome into a registered flush or resolve-OK broadcast toward the ROB, with only one branch in flight at a time.

Parameters:
NUM_REQ, 4, number of requesting reservation-station entries (>=2)
TAG_W, 3, ROB tag width
DATA_W, 32, operand width
CHECK_LAT, 4, cycles to wait for a misprediction report after issue (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-entry branch ready to check
req_tag  input  NUM_REQ*TAG_W  per-entry ROB tag, entry i at [i*TAG_W +: TAG_W]
req_rs1_data  input  NUM_REQ*DATA_W  per-entry rs1 operand
req_rs2_data  input  NUM_REQ*DATA_W  per-entry rs2 operand
req_grant  output  NUM_REQ  one-hot, one-cycle pulse: entry accepted, requester deasserts next cycle
bc_valid  output  1  issue pulse to branch-check unit
bc_rs1_data  output  DATA_W  latched rs1
bc_rs2_data  output  DATA_W  latched rs2
bc_tag  output  TAG_W  latched tag
bc_result_valid  input  1  misprediction report from branch-check unit
bc_result_tag  input  TAG_W  tag of reported misprediction
flush_in  input  1  external pipeline flush
flush_out  output  1  one-cycle misprediction flush to ROB
flush_tag  output  TAG_W  tag of mispredicted branch
resolve_ok  output  1  one-cycle pulse: branch resolved, no misprediction
resolve_tag  output  TAG_W  tag for resolve_ok
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0; operand/tag latches 0; wait counter 0; round-robin pointer = NUM_REQ-1, so entry 0 has first priority.
- States: IDLE, ISSUE, WAIT, REPORT. All outputs are registered.
- IDLE:
  - If any req_valid is set, select the first valid entry searching from pointer+1 modulo NUM_REQ.
  - On the clock edge: latch that entry's tag and operands; pulse req_grant[i] for the following cycle; set pointer=i; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: lasts 1 cycle; bc_valid=1 with latched operands and tag; load counter=CHECK_LAT-1; go to WAIT.
- WAIT:
  - bc_valid=0. bc_rs1_data, bc_rs2_data and bc_tag hold their values until the next grant.
  - Misprediction: bc_result_valid=1 with bc_result_tag==latched tag, in ISSUE or WAIT, sets the mispredict flag and moves to REPORT on that edge.
  - A report with a mismatched tag is ignored.
  - If the counter reaches 0 with no match, go to REPORT with mispredict flag=0. Otherwise decrement the counter.
  - A report arriving after the window is ignored.
- REPORT: lasts 1 cycle.
  - Mispredict flag=1: flush_out=1, flush_tag=latched tag.
  - Mispredict flag=0: resolve_ok=1, resolve_tag=latched tag.
  - Then go to IDLE. No grant is issued in REPORT, so the minimum spacing between issues is CHECK_LAT+3 cycles when no misprediction occurs.
- Misprediction latency: report at cycle t produces flush_out at cycle t+1.
- flush_in=1 in any state:
  - The next state is IDLE; the in-flight branch is dropped; no flush_out or resolve_ok for it; req_grant is forced to 0 on the following cycle.
  - The pointer is unchanged.
  - flush_in has priority over a same-cycle bc_result_valid.
- req_valid is sampled only in IDLE. Changes to a requester's operands while it is not granted are ignored.
- After a grant, the pointer guarantees that every continuously valid entry is granted within NUM_REQ grants.
- Async reset mid-operation aborts immediately and clears all outputs, including an in-progress bc_valid or flush_out pulse.

Test Plan:
- Single request: req_valid=0001, tag=5, rs1=rs2=0x10, branch-check unit reports tag 5 two cycles after bc_valid → req_grant=0001, bc_valid for 1 cycle, flush_out=1 with flush_tag=5 one cycle after the report, busy low afterward.
- No misprediction: req_valid=0010, tag=3, rs1=1, rs2=2, no report → resolve_ok=1 with resolve_tag=3 exactly CHECK_LAT+1 cycles after bc_valid, flush_out stays 0.
- Round-robin: req_valid=1111 held, all checks resolve OK → grant order 0,1,2,3,0, each grant CHECK_LAT+3 cycles apart.
- Wrong tag: in-flight tag=6, bc_result_valid with tag=2 → ignored, resolve_ok with tag 6 at window end.
- Flush collision: flush_in=1 in the same cycle as a matching report → no flush_out, no resolve_ok, state IDLE next cycle, next grant goes to pointer+1.
- Reset mid-WAIT: drop rst_n during WAIT → all outputs 0 immediately; after release, the first grant goes to entry 0.
